// File: rtl/shift_operand_decoder.sv
// rtl/shift_operand_decoder.sv - ARM data-processing shifter-operand decoder
//
// Decodes the shifter operand of an ARM data-processing instruction into the
// operands of a barrel shifter. It fetches Rm and, for register shifts, Rs
// through a one-cycle-latency register-file read port.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      instruction handshake (instr, cpsr_c)
//   rf_rd_en/rf_addr       register-file read request
//   rf_rdata               read data, valid the cycle after rf_rd_en
//   out_valid/out_ready    operand handshake
//   Shift_Data/Shift_Num   operand to shift / shift amount
//   SHIFT_OP               {type[1:0], register/rotate-form bit}
//   Carry_flag             C flag captured at acceptance
//
// Build option: SHIFT_DEC_RS_BYPASS_EN - a register shift whose Rs equals Rm
// reuses the Rm read data as the shift amount and skips the Rs read.

module shift_operand_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        cpsr_c,
    output logic        rf_rd_en,
    output logic [3:0]  rf_addr,
    input  logic [31:0] rf_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Shift_Data,
    output logic [7:0]  Shift_Num,
    output logic [2:0]  SHIFT_OP,
    output logic        Carry_flag
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_RM = 3'd1,
        WT_RM = 3'd2,
        WT_RS = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic        rf_rd_en_q, rf_rd_en_d;
    logic [3:0]  rf_addr_q, rf_addr_d;
    logic [31:0] shift_data_q, shift_data_d;
    logic [7:0]  shift_num_q, shift_num_d;
    logic [2:0]  shift_op_q, shift_op_d;
    logic        carry_q, carry_d;
    // Only the instruction fields still needed after acceptance are kept.
    logic [3:0]  rs_addr_q, rs_addr_d;
    logic        reg_shift_q, reg_shift_d;
    logic        rs_bypass_q, rs_bypass_d;

    logic        in_fire;
    logic        rs_same_as_rm;

    // Condition, opcode, S and Rn/Rd fields play no part in the operand.
    logic        unused_instr_bits;
    assign unused_instr_bits = ^{instr[31:26], instr[24:12]};

    assign in_fire = in_valid && (state_q == IDLE);

`ifdef SHIFT_DEC_RS_BYPASS_EN
    assign rs_same_as_rm = (instr[11:8] == instr[3:0]);
`else
    assign rs_same_as_rm = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        rf_rd_en_d   = 1'b0;
        rf_addr_d    = rf_addr_q;
        shift_data_d = shift_data_q;
        shift_num_d  = shift_num_q;
        shift_op_d   = shift_op_q;
        carry_d      = carry_q;
        rs_addr_d    = rs_addr_q;
        reg_shift_d  = reg_shift_q;
        rs_bypass_d  = rs_bypass_q;

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    carry_d     = cpsr_c;
                    rs_addr_d   = instr[11:8];
                    reg_shift_d = instr[4];
                    rs_bypass_d = instr[4] && rs_same_as_rm;
                    if (instr[25]) begin
                        // Rotated 8-bit immediate: rotate amount is 2*rot.
                        shift_data_d = {24'b0, instr[7:0]};
                        shift_num_d  = {3'b0, instr[11:8], 1'b0};
                        shift_op_d   = 3'b111;
                        out_valid_d  = 1'b1;
                        state_d      = OUT;
                    end else begin
                        shift_op_d  = {instr[6:5], instr[4]};
                        shift_num_d = instr[4] ? 8'h00 : {3'b0, instr[11:7]};
                        rf_rd_en_d  = 1'b1;
                        rf_addr_d   = instr[3:0];
                        state_d     = RD_RM;
                    end
                end
            end
            RD_RM: begin
                // Issue the Rs read so its data arrives during WT_RS.
                if (reg_shift_q && !rs_bypass_q) begin
                    rf_rd_en_d = 1'b1;
                    rf_addr_d  = rs_addr_q;
                end
                state_d = WT_RM;
            end
            WT_RM: begin
                shift_data_d = rf_rdata;
                if (reg_shift_q && !rs_bypass_q) begin
                    state_d = WT_RS;
                end else begin
                    if (rs_bypass_q) begin
                        shift_num_d = rf_rdata[7:0];
                    end
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            WT_RS: begin
                shift_num_d = rf_rdata[7:0];
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_addr_q    <= 4'h0;
            shift_data_q <= 32'h0;
            shift_num_q  <= 8'h0;
            shift_op_q   <= 3'b000;
            carry_q      <= 1'b0;
            rs_addr_q    <= 4'h0;
            reg_shift_q  <= 1'b0;
            rs_bypass_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_addr_q    <= rf_addr_d;
            shift_data_q <= shift_data_d;
            shift_num_q  <= shift_num_d;
            shift_op_q   <= shift_op_d;
            carry_q      <= carry_d;
            rs_addr_q    <= rs_addr_d;
            reg_shift_q  <= reg_shift_d;
            rs_bypass_q  <= rs_bypass_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign rf_rd_en   = rf_rd_en_q;
    assign rf_addr    = rf_addr_q;
    assign Shift_Data = shift_data_q;
    assign Shift_Num  = shift_num_q;
    assign SHIFT_OP   = shift_op_q;
    assign Carry_flag = carry_q;

endmodule
